exu_muldiv_issue: RTL and testbench
===================================

Name: exu_muldiv_issue

Overview:
- EX-stage initiator for the iterative multiply and divide units, on the requester side of the start/busy/ready protocol.
- Accepts one M-extension op per handshake from decode and routes operands to the mul or div unit.
- Holds start for the whole calculation, then captures the result and presents it to writeback with backpressure.
- Handles pipeline flush and a watchdog timeout; stalls the front end while an op is outstanding.

Parameters:
REG_DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, register address width
TIMEOUT_CYCLES, 64, max cycles in ISSUE before abort (must exceed unit latency, mul=18)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid_i  in  1  decode has M-op
req_ready_o  out  1  block accepts op
req_is_div_i  in  1  0=mul unit, 1=div unit
req_op_i  in  4  one-hot op (mul: 0001 MUL,0010 MULH,0100 MULHSU,1000 MULHU; div: 0001 DIV,0010 DIVU,0100 REM,1000 REMU)
req_rs1_i  in  REG_DATA_WIDTH  operand A (multiplicand/dividend)
req_rs2_i  in  REG_DATA_WIDTH  operand B (multiplier/divisor)
req_waddr_i  in  REG_ADDR_WIDTH  destination register
flush_i  in  1  kill outstanding op
mul_start_o / div_start_o  out  1  unit start, held during calc
mul_a_o, mul_b_o, div_a_o, div_b_o  out  REG_DATA_WIDTH  operands (stable while start high)
mul_op_o / div_op_o  out  4  op
mul_waddr_o / div_waddr_o  out  REG_ADDR_WIDTH  waddr to unit
mul_result_i / div_result_i  in  REG_DATA_WIDTH  unit result
mul_ready_i / div_ready_i  in  1  one-cycle result pulse
wb_valid_o  out  1  result valid
wb_ready_i  in  1  writeback accepts
wb_data_o  out  REG_DATA_WIDTH  result
wb_waddr_o  out  REG_ADDR_WIDTH  destination
stall_o  out  1  op outstanding
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- States are IDLE, ISSUE and WB. Reset puts the FSM in IDLE and clears all outputs, counter and captured regs to 0.
- IDLE
  - req_ready_o = !flush_i.
  - On req_valid_i && req_ready_o: capture is_div, op, rs1, rs2, waddr; clear cycle counter; go to ISSUE.
- ISSUE
  - Selected start_o = 1 (combinational from state); the other unit's start stays 0.
  - Operands, op and waddr are driven from captured regs and stay constant.
  - Counter increments each cycle.
  - Selected ready_i = 1: latch result into wb_data, go to WB.
- WB
  - wb_valid_o = 1; wb_data_o and wb_waddr_o are held stable.
  - On wb_ready_i: go to IDLE.
- Start is low in IDLE and WB, so there is always at least one start-low cycle between ops. This cancels the unit's one-cycle spurious restart after it returns to its idle state with start still high.
- The unit's own reg_waddr output is ignored. Captured waddr is authoritative.
- stall_o = (state != IDLE).
- Flush
  - In ISSUE or WB: go to IDLE; the result is discarded and wb_valid_o is not raised.
  - Flush with ready in the same cycle: flush wins.
  - Flush in IDLE blocks acceptance that cycle.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 in ISSUE without ready, pulse timeout_o for one cycle, drop start and go to IDLE without writeback.
- Ready from the unselected unit, or any ready outside ISSUE, is ignored.
- Reset mid-op: returns to IDLE next edge with start low; the unit also resets.
- Latency: accept edge to wb_valid_o = unit latency + 1 cycle.

Decomposition:
- Shared package/defines:
  - state encodings (IDLE/ISSUE/WB);
  - one-hot mul and div op constants;
  - REG_DATA_WIDTH/REG_ADDR_WIDTH macros, reused from the existing defines.
- One natural sub-module: muldiv_watchdog (counter + timeout compare; inputs clear/enable).

Test Plan:
1. MUL 6*7 (is_div=0, op 0001, waddr 5), wb_ready_i=1 → mul_start_o high ~18 cycles; wb_valid_o one cycle, wb_data_o=42, wb_waddr_o=5; start low ≥1 cycle before next op.
2. MULHU 0xFFFFFFFF*0xFFFFFFFF → wb_data_o=0xFFFFFFFE. Hold wb_ready_i=0 for 5 cycles → data stable, req_ready_o=0 throughout, stall_o=1.
3. DIV -7/2 (op 0001, is_div=1) → div_start_o only, wb_data_o=0xFFFFFFFD. Spurious mul_ready_i pulse mid-op is ignored.
4. Flush 3 cycles into a MUL → start drops next cycle, no wb_valid_o, IDLE. New MUL issued immediately after gives the correct result.
5. Flush coincident with mul_ready_i → no writeback. Flush coincident with req_valid_i in IDLE → not accepted.
6. Stub unit that never asserts ready → timeout_o pulses at cycle 64 after accept, start low, stall_o=0. Reset asserted mid-ISSUE → all outputs 0 next cycle.

Source files
------------

// File: rtl/exu_muldiv_issue_pkg.sv
// Shared types and constants for the EX-stage mul/div issue block.
// Width defaults mirror the register-file widths used across the execute stage.
package exu_muldiv_issue_pkg;

  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWb    = 2'd2
  } state_e;

  localparam logic [3:0] OpMul    = 4'b0001;
  localparam logic [3:0] OpMulh   = 4'b0010;
  localparam logic [3:0] OpMulhsu = 4'b0100;
  localparam logic [3:0] OpMulhu  = 4'b1000;

  localparam logic [3:0] OpDiv  = 4'b0001;
  localparam logic [3:0] OpDivu = 4'b0010;
  localparam logic [3:0] OpRem  = 4'b0100;
  localparam logic [3:0] OpRemu = 4'b1000;

endpackage

// File: rtl/exu_muldiv_issue_if.sv
// Bundle of decode, mul/div unit and writeback signals around the issue block.
// master = the issue block itself; slave = decode, units and writeback around it.
interface exu_muldiv_issue_if
  import exu_muldiv_issue_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = RegDataWidth,
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidth
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_is_div_i;
  logic [3:0]                req_op_i;
  logic [REG_DATA_WIDTH-1:0] req_rs1_i;
  logic [REG_DATA_WIDTH-1:0] req_rs2_i;
  logic [REG_ADDR_WIDTH-1:0] req_waddr_i;
  logic                      flush_i;

  logic                      mul_start_o;
  logic                      div_start_o;
  logic [REG_DATA_WIDTH-1:0] mul_a_o;
  logic [REG_DATA_WIDTH-1:0] mul_b_o;
  logic [REG_DATA_WIDTH-1:0] div_a_o;
  logic [REG_DATA_WIDTH-1:0] div_b_o;
  logic [3:0]                mul_op_o;
  logic [3:0]                div_op_o;
  logic [REG_ADDR_WIDTH-1:0] mul_waddr_o;
  logic [REG_ADDR_WIDTH-1:0] div_waddr_o;
  logic [REG_DATA_WIDTH-1:0] mul_result_i;
  logic [REG_DATA_WIDTH-1:0] div_result_i;
  logic                      mul_ready_i;
  logic                      div_ready_i;

  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [REG_DATA_WIDTH-1:0] wb_data_o;
  logic [REG_ADDR_WIDTH-1:0] wb_waddr_o;
  logic                      stall_o;
  logic                      timeout_o;

  modport master (
    input  req_valid_i, req_is_div_i, req_op_i, req_rs1_i, req_rs2_i, req_waddr_i, flush_i,
    input  mul_result_i, div_result_i, mul_ready_i, div_ready_i, wb_ready_i,
    output req_ready_o, mul_start_o, div_start_o, mul_a_o, mul_b_o, div_a_o, div_b_o,
    output mul_op_o, div_op_o, mul_waddr_o, div_waddr_o,
    output wb_valid_o, wb_data_o, wb_waddr_o, stall_o, timeout_o
  );

  modport slave (
    output req_valid_i, req_is_div_i, req_op_i, req_rs1_i, req_rs2_i, req_waddr_i, flush_i,
    output mul_result_i, div_result_i, mul_ready_i, div_ready_i, wb_ready_i,
    input  req_ready_o, mul_start_o, div_start_o, mul_a_o, mul_b_o, div_a_o, div_b_o,
    input  mul_op_o, div_op_o, mul_waddr_o, div_waddr_o,
    input  wb_valid_o, wb_data_o, wb_waddr_o, stall_o, timeout_o
  );

endinterface

// File: rtl/exu_muldiv_issue_watchdog.sv
// Cycle counter for an outstanding mul/div op; flags when the op has run too long.
module exu_muldiv_issue_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/exu_muldiv_issue.sv
// EX-stage initiator for the iterative mul/div units: holds start for the whole
// calculation, captures the result and hands it to writeback under backpressure.
module exu_muldiv_issue
  import exu_muldiv_issue_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = RegDataWidth,
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidth,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  exu_muldiv_issue_if.master bus
);

  state_e state_q, state_d;

  logic                      is_div_q;
  logic [3:0]                op_q;
  logic [REG_DATA_WIDTH-1:0] rs1_q, rs2_q, wb_data_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;
  logic                      timeout_q, timeout_d;
  logic                      capture, latch_result, expired, sel_ready, req_ready;

  // Only the unit we started may complete the op; the other one's ready is noise.
  assign sel_ready = is_div_q ? bus.div_ready_i : bus.mul_ready_i;

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    latch_result = 1'b0;
    timeout_d    = 1'b0;
    req_ready    = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = !bus.flush_i;
        if (bus.req_valid_i && !bus.flush_i) begin
          capture = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.flush_i) begin
          state_d = StIdle;
        end else if (sel_ready) begin
          latch_result = 1'b1;
          state_d      = StWb;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StWb: begin
        if (bus.flush_i || bus.wb_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      waddr_q   <= '0;
      wb_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      if (capture) begin
        is_div_q <= bus.req_is_div_i;
        op_q     <= bus.req_op_i;
        rs1_q    <= bus.req_rs1_i;
        rs2_q    <= bus.req_rs2_i;
        waddr_q  <= bus.req_waddr_i;
      end
      if (latch_result) begin
        wb_data_q <= is_div_q ? bus.div_result_i : bus.mul_result_i;
      end
    end
  end

  exu_muldiv_issue_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (capture),
    .enable_i  (state_q == StIssue),
    .expired_o (expired)
  );

  // Start is low in IDLE and WB, guaranteeing a start-low gap between ops.
  assign bus.mul_start_o = (state_q == StIssue) && !is_div_q;
  assign bus.div_start_o = (state_q == StIssue) && is_div_q;
  assign bus.mul_a_o     = rs1_q;
  assign bus.mul_b_o     = rs2_q;
  assign bus.div_a_o     = rs1_q;
  assign bus.div_b_o     = rs2_q;
  assign bus.mul_op_o    = op_q;
  assign bus.div_op_o    = op_q;
  assign bus.mul_waddr_o = waddr_q;
  assign bus.div_waddr_o = waddr_q;

  assign bus.req_ready_o = req_ready;
  assign bus.wb_valid_o  = (state_q == StWb) && !bus.flush_i;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.wb_waddr_o  = waddr_q;
  assign bus.stall_o     = (state_q != StIdle);
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_exu_muldiv_issue.sv
// Directed bench for exu_muldiv_issue with simple fixed-latency mul/div unit stubs.
module tb_exu_muldiv_issue;
  import exu_muldiv_issue_pkg::*;

  localparam int MulLat = 18;
  localparam int DivLat = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_muldiv_issue_if #(.REG_DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  exu_muldiv_issue #(
    .REG_DATA_WIDTH (32),
    .REG_ADDR_WIDTH (5),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // Unit stubs: ready pulses after a fixed number of start-high cycles.
  int   mul_cnt, div_cnt;
  logic mul_rdy_q, div_rdy_q;
  bit   mul_en = 1'b1;
  bit   mul_force = 1'b0;

  always @(posedge clk) begin
    if (rst || !bus.mul_start_o) begin
      mul_cnt   <= 0;
      mul_rdy_q <= 1'b0;
    end else begin
      mul_cnt   <= mul_cnt + 1;
      mul_rdy_q <= mul_en && (mul_cnt == MulLat - 2);
    end
  end

  always @(posedge clk) begin
    if (rst || !bus.div_start_o) begin
      div_cnt   <= 0;
      div_rdy_q <= 1'b0;
    end else begin
      div_cnt   <= div_cnt + 1;
      div_rdy_q <= (div_cnt == DivLat - 2);
    end
  end

  logic [63:0] prod;
  assign prod             = {32'b0, bus.mul_a_o} * {32'b0, bus.mul_b_o};
  assign bus.mul_result_i = (bus.mul_op_o == OpMulhu) ? prod[63:32] : prod[31:0];
  assign bus.div_result_i = (bus.div_b_o == 32'd0) ? 32'hFFFF_FFFF :
                            32'($signed(bus.div_a_o) / $signed(bus.div_b_o));
  assign bus.mul_ready_i  = mul_rdy_q | mul_force;
  assign bus.div_ready_i  = div_rdy_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present an op at a negedge and hold it until the block accepts it.
  task automatic issue(input bit is_div, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa);
    bit accepted = 1'b0;
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_is_div_i = is_div;
    bus.req_op_i     = op;
    bus.req_rs1_i    = a;
    bus.req_rs2_i    = b;
    bus.req_waddr_i  = wa;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.req_ready_o) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("issue_accept", 32'(accepted), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(output int ms, output int ds, output bit ok);
    ms = 0;
    ds = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.mul_start_o) ms++;
      if (bus.div_start_o) ds++;
      @(posedge clk);
      #1;
      if (bus.wb_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  ms, ds, k, hits;
    bit  ok;
    logic [31:0] held;

    bus.req_valid_i  = 1'b0;
    bus.req_is_div_i = 1'b0;
    bus.req_op_i     = '0;
    bus.req_rs1_i    = '0;
    bus.req_rs2_i    = '0;
    bus.req_waddr_i  = '0;
    bus.flush_i      = 1'b0;
    bus.wb_ready_i   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_mul_start", 32'(bus.mul_start_o), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_wb_data", bus.wb_data_o, 32'd0);
    chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // MUL 6*7
    issue(1'b0, OpMul, 32'd6, 32'd7, 5'd5);
    wait_wb(ms, ds, ok);
    chk("mul_wb_seen", 32'(ok), 32'd1);
    chk("mul_start_cycles", 32'(ms), 32'(MulLat));
    chk("mul_no_div_start", 32'(ds), 32'd0);
    chk("mul_data", bus.wb_data_o, 32'd42);
    chk("mul_waddr", 32'(bus.wb_waddr_o), 32'd5);
    @(posedge clk);
    #1;
    chk("mul_wb_one_cycle", 32'(bus.wb_valid_o), 32'd0);
    chk("mul_start_gap", 32'(bus.mul_start_o), 32'd0);
    chk("mul_idle_stall", 32'(bus.stall_o), 32'd0);

    // MULHU with writeback backpressure
    bus.wb_ready_i = 1'b0;
    issue(1'b0, OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    wait_wb(ms, ds, ok);
    chk("mulhu_wb_seen", 32'(ok), 32'd1);
    chk("mulhu_data", bus.wb_data_o, 32'hFFFF_FFFE);
    held = bus.wb_data_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.wb_valid_o), 32'd1);
      chk("bp_data", bus.wb_data_o, 32'hFFFF_FFFE);
      chk("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
      chk("bp_stall", 32'(bus.stall_o), 32'd1);
    end
    @(negedge clk);
    bus.wb_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_released", 32'(bus.wb_valid_o), 32'd0);

    // DIV -7/2 with a spurious mul ready mid-op
    issue(1'b1, OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mul_force = 1'b1;
    @(posedge clk);
    #1;
    mul_force = 1'b0;
    chk("div_spur_stall", 32'(bus.stall_o), 32'd1);
    chk("div_spur_no_wb", 32'(bus.wb_valid_o), 32'd0);
    chk("div_start", 32'(bus.div_start_o), 32'd1);
    chk("div_no_mul_start", 32'(bus.mul_start_o), 32'd0);
    chk("div_op", 32'(bus.div_op_o), 32'd1);
    wait_wb(ms, ds, ok);
    chk("div_wb_seen", 32'(ok), 32'd1);
    chk("div_mul_start_cnt", 32'(ms), 32'd0);
    chk("div_data", bus.wb_data_o, 32'hFFFF_FFFD);
    chk("div_waddr", 32'(bus.wb_waddr_o), 32'd12);

    // Flush three cycles into a MUL, then a fresh MUL straight after
    issue(1'b0, OpMul, 32'd6, 32'd7, 5'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    chk("flush_start_low", 32'(bus.mul_start_o), 32'd0);
    chk("flush_stall", 32'(bus.stall_o), 32'd0);
    chk("flush_no_wb", 32'(bus.wb_valid_o), 32'd0);
    issue(1'b0, OpMul, 32'd9, 32'd9, 5'd3);
    wait_wb(ms, ds, ok);
    chk("reissue_wb_seen", 32'(ok), 32'd1);
    chk("reissue_cycles", 32'(ms), 32'(MulLat));
    chk("reissue_data", bus.wb_data_o, 32'd81);
    chk("reissue_waddr", 32'(bus.wb_waddr_o), 32'd3);

    // Flush coincident with mul ready
    issue(1'b0, OpMul, 32'd2, 32'd3, 5'd4);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.mul_ready_i) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fr_ready_seen", 32'(ok), 32'd1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    chk("fr_no_wb", 32'(bus.wb_valid_o), 32'd0);
    chk("fr_stall", 32'(bus.stall_o), 32'd0);
    hits = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.wb_valid_o) hits++;
    end
    chk("fr_no_late_wb", 32'(hits), 32'd0);

    // Flush coincident with a request in IDLE
    @(negedge clk);
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    #1;
    chk("fi_req_ready", 32'(bus.req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    chk("fi_not_accepted", 32'(bus.stall_o), 32'd0);

    // Watchdog with a unit that never answers
    mul_en = 1'b0;
    issue(1'b0, OpMul, 32'd1, 32'd1, 5'd7);
    k = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.timeout_o) begin
        k = i;
        break;
      end
    end
    chk("to_cycle", 32'(k), 32'd64);
    chk("to_start_low", 32'(bus.mul_start_o), 32'd0);
    chk("to_stall", 32'(bus.stall_o), 32'd0);
    chk("to_no_wb", 32'(bus.wb_valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("to_pulse_one", 32'(bus.timeout_o), 32'd0);
    mul_en = 1'b1;

    // Reset in the middle of ISSUE
    issue(1'b0, OpMul, 32'd5, 32'd5, 5'd8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_mul_start", 32'(bus.mul_start_o), 32'd0);
    chk("mr_div_start", 32'(bus.div_start_o), 32'd0);
    chk("mr_stall", 32'(bus.stall_o), 32'd0);
    chk("mr_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("mr_timeout", 32'(bus.timeout_o), 32'd0);
    chk("mr_mul_a", bus.mul_a_o, 32'd0);
    chk("mr_mul_b", bus.mul_b_o, 32'd0);
    chk("mr_mul_op", 32'(bus.mul_op_o), 32'd0);
    chk("mr_wb_data", bus.wb_data_o, 32'd0);
    chk("mr_wb_waddr", 32'(bus.wb_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
